// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RAM width codes, the control
// FSM state type and the access-size decode.
//   MEM_B/MEM_H/MEM_W : values of code[1:0] for byte/half/word accesses
//   MEM_U             : bit index of the unsigned flag inside the 3-bit code
//   size_from_code    : access size in bytes (1/2/4); a set word bit wins
package lsu_pkg;

  localparam logic [1:0] MEM_B = 2'b00;
  localparam logic [1:0] MEM_H = 2'b01;
  localparam logic [1:0] MEM_W = 2'b10;
  localparam int unsigned MEM_U = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_BYTE,
    ST_RESP
  } lsu_state_e;

  function automatic logic [2:0] size_from_code(input logic [2:0] code);
    case (code[1:0])
      MEM_B:   return 3'd1;
      MEM_H:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Combinational load-data extension, shared with the writeback stage.
//   data  : LSB-aligned raw load data
//   code  : [2] unsigned, [1] word, [0] half (00 = byte)
//   rdata : data sign- or zero-extended to 32 bits
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] data,
  input  logic [2:0]  code,
  output logic [31:0] rdata
);

  always_comb begin
    rdata = data;
    case (code[1:0])
      MEM_B:   rdata = code[MEM_U] ? {24'h0, data[7:0]}
                                   : {{24{data[7]}}, data[7:0]};
      MEM_H:   rdata = code[MEM_U] ? {16'h0, data[15:0]}
                                   : {{16{data[15]}}, data[15:0]};
      default: rdata = data;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit between the MEM stage and the byte-addressed data RAM.
// Accepts one request at a time, range-checks it up front, performs aligned
// accesses in one RAM cycle and (when MISALIGN_EN) splits misaligned ones into
// byte accesses, then returns a single-cycle response.
//   clk, rst_n           : clock, synchronous active-low reset
//   req_*                : request handshake (valid/ready), we, addr, wdata, code
//   resp_*               : one-cycle response pulse with load data and fault flags
//   mem_addr/dina/wea/rea/u_b_h_w : RAM port, decoded from registered state
//   mem_douta, mem_*_access_fault : RAM combinational read data and faults
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_ADDR_BITS = 7,
  parameter bit          MISALIGN_EN   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_u_b_h_w,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_l_fault,
  output logic        resp_s_fault,
  output logic        resp_misaligned,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_dina,
  output logic        mem_wea,
  output logic        mem_rea,
  output logic [2:0]  mem_u_b_h_w,
  input  logic [31:0] mem_douta,
  input  logic        mem_l_access_fault,
  input  logic        mem_s_access_fault
);

  lsu_state_e state, state_nx;
  logic [1:0] cnt, cnt_nx;

  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  code_q;
  logic [31:0] asm_q;
  logic        l_fault_q;
  logic        s_fault_q;
  logic        mis_q;

  // Incoming request classification, evaluated during the handshake cycle
  logic [2:0]  size_in;
  logic [31:0] last_in;
  logic        mis_in;
  logic        oor_in;

  always_comb begin
    size_in = size_from_code(req_u_b_h_w);
    last_in = req_addr + 32'(size_in) - 32'd1;
    mis_in  = (req_u_b_h_w[0] & req_addr[0]) | (req_u_b_h_w[1] & |req_addr[1:0]);
    oor_in  = |req_addr[31:MEM_ADDR_BITS] | |last_in[31:MEM_ADDR_BITS];
  end

  logic [1:0] last_cnt;
  logic       ram_fault;

  always_comb begin
    last_cnt  = 2'(size_from_code(code_q) - 3'd1);
    ram_fault = mem_l_access_fault | mem_s_access_fault;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          cnt_nx = '0;
          if (oor_in || (mis_in && !MISALIGN_EN)) state_nx = ST_RESP;
          else if (mis_in)                        state_nx = ST_BYTE;
          else                                    state_nx = ST_ACCESS;
        end
      end
      ST_ACCESS: state_nx = ST_RESP;
      ST_BYTE: begin
        if (ram_fault || cnt == last_cnt) state_nx = ST_RESP;
        else                              cnt_nx   = cnt + 2'd1;
      end
      ST_RESP: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      code_q    <= '0;
      asm_q     <= '0;
      l_fault_q <= 1'b0;
      s_fault_q <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            we_q      <= req_we;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            code_q    <= req_u_b_h_w;
            asm_q     <= '0;
            // Range fault takes precedence over the misalignment report
            l_fault_q <= oor_in & ~req_we;
            s_fault_q <= oor_in & req_we;
            mis_q     <= mis_in & ~oor_in & ~MISALIGN_EN;
          end
        end
        ST_ACCESS: begin
          asm_q     <= mem_douta;
          l_fault_q <= ram_fault & ~we_q;
          s_fault_q <= ram_fault & we_q;
        end
        ST_BYTE: begin
          if (ram_fault) begin
            l_fault_q <= ~we_q;
            s_fault_q <= we_q;
          end else if (!we_q) begin
            asm_q[{cnt, 3'b000} +: 8] <= mem_douta[7:0];
          end
        end
        default: ;
      endcase
    end
  end

  // RAM port. Enables are also qualified by rst_n so a reset landing in the
  // middle of a split store stops the RAM commit in that same cycle.
  always_comb begin
    mem_addr    = '0;
    mem_dina    = '0;
    mem_wea     = 1'b0;
    mem_rea     = 1'b0;
    mem_u_b_h_w = '0;
    case (state)
      ST_ACCESS: begin
        mem_addr    = addr_q;
        mem_dina    = wdata_q;
        mem_u_b_h_w = code_q;
        mem_wea     = we_q & rst_n;
        mem_rea     = ~we_q & rst_n;
      end
      ST_BYTE: begin
        mem_addr      = addr_q + 32'(cnt);
        mem_dina[7:0] = wdata_q[{cnt, 3'b000} +: 8];
        mem_u_b_h_w   = we_q ? 3'b000 : 3'b100;
        mem_wea       = we_q & rst_n;
        mem_rea       = ~we_q & rst_n;
      end
      default: ;
    endcase
  end

  logic [31:0] ext_data;

  lsu_load_extend u_ext (
    .data  (asm_q),
    .code  (code_q),
    .rdata (ext_data)
  );

  logic any_fault;

  always_comb begin
    any_fault       = l_fault_q | s_fault_q | mis_q;
    req_ready       = (state == ST_IDLE);
    resp_valid      = (state == ST_RESP);
    resp_l_fault    = resp_valid & l_fault_q;
    resp_s_fault    = resp_valid & s_fault_q;
    resp_misaligned = resp_valid & mis_q;
    resp_rdata      = (resp_valid && !we_q && !any_fault) ? ext_data : '0;
  end

endmodule
